// File: rtl/frame_readout.sv
// Frame capture/snapshot buffer with addressed readout for the microcontroller bus.
// Only complete, correctly sized frames are committed from capture into the snapshot.
module frame_readout #(
    parameter int unsigned FRAME_BYTES = 12,
    parameter int unsigned ADDR_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    input  logic                  frame_end,
    input  logic                  hold,
    input  logic                  read_ack,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            parallel_out,
    output logic                  full,
    output logic                  overrun
);
    localparam int unsigned            PTR_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [PTR_W-1:0]       PTR_FULL    = PTR_W'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH-1:0]  STATUS_ADDR = ADDR_WIDTH'(FRAME_BYTES);

    typedef enum logic {COLLECT, PENDING} state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       capture  [FRAME_BYTES];
    logic [7:0]       snapshot [FRAME_BYTES];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] byte_count;
    logic             too_long;
    logic [4:0]       bad_count;
    logic             byte_accept;
    logic             byte_extra;
    logic             frame_bad;
    logic             commit;
    logic             set_overrun;
    logic [7:0]       rd_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        byte_accept = 1'b0;
        byte_extra  = 1'b0;
        byte_count  = wr_ptr;
        frame_bad   = 1'b0;
        commit      = 1'b0;
        set_overrun = 1'b0;
        case (state)
            COLLECT: begin
                byte_accept = byte_valid && (wr_ptr < PTR_FULL);
                byte_extra  = byte_valid && (wr_ptr == PTR_FULL);
                byte_count  = wr_ptr + PTR_W'(byte_accept);
                if (frame_end) begin
                    // A dropped same-cycle byte leaves byte_count at FRAME_BYTES, so it must be excluded here.
                    if (!too_long && !byte_extra && (byte_count == PTR_FULL)) begin
                        if (hold) begin
                            state_next = PENDING;
                        end else begin
                            commit = 1'b1;
                        end
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (!hold) begin
                    commit     = 1'b1;
                    state_next = COLLECT;
                end
                if (byte_valid || frame_end) begin
                    set_overrun = 1'b1;
                end
            end
            default: ;
        endcase
        if (commit && full && !read_ack) begin
            set_overrun = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            too_long  <= 1'b0;
            bad_count <= '0;
            for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                capture[i] <= '0;
            end
        end else begin
            if (state == COLLECT) begin
                if (frame_end) begin
                    wr_ptr   <= '0;
                    too_long <= 1'b0;
                end else begin
                    if (byte_accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (byte_extra) begin
                        too_long <= 1'b1;
                    end
                end
            end
            if (byte_accept) begin
                capture[wr_ptr] <= byte_data;
            end
            if (frame_bad && (bad_count != 5'd31)) begin
                bad_count <= bad_count + 5'd1;
            end
        end
    end

    // Commit uses the capture contents as they will be after this edge, so a final byte
    // arriving together with frame_end lands in the snapshot in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                snapshot[i] <= '0;
            end
        end else if (commit) begin
            for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                snapshot[i] <= (byte_accept && (wr_ptr == PTR_W'(i))) ? byte_data : capture[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (commit) begin
                full <= 1'b1;
            end else if (read_ack) begin
                full <= 1'b0;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (read_ack) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (address == STATUS_ADDR) begin
            rd_data = {full, overrun, (state == PENDING), bad_count};
        end else begin
            for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                if (address == ADDR_WIDTH'(i)) begin
                    rd_data = snapshot[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parallel_out <= '0;
        end else begin
            parallel_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_frame_readout.sv
// Self-checking bench for frame_readout: default 12-byte instance plus a 20-byte instance.
// Expected read data is queued when a read is issued and compared when it returns.
module tb_frame_readout;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] byte_data = '0;
    logic       byte_valid = 1'b0;
    logic       frame_end = 1'b0;
    logic       hold = 1'b0;
    logic       read_ack = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] parallel_out;
    logic       full;
    logic       overrun;

    logic [7:0] byte_data_p = '0;
    logic       byte_valid_p = 1'b0;
    logic       frame_end_p = 1'b0;
    logic       hold_p = 1'b0;
    logic       read_ack_p = 1'b0;
    logic [4:0] address_p = '0;
    logic [7:0] parallel_out_p;
    logic       full_p;
    logic       overrun_p;

    logic [7:0] exp_q[$];
    logic [7:0] exp;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    frame_readout #(.FRAME_BYTES(12), .ADDR_WIDTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_end(frame_end), .hold(hold), .read_ack(read_ack), .address(address),
        .parallel_out(parallel_out), .full(full), .overrun(overrun)
    );

    frame_readout #(.FRAME_BYTES(20), .ADDR_WIDTH(5)) dut_p (
        .clock(clock), .reset_n(reset_n), .byte_data(byte_data_p), .byte_valid(byte_valid_p),
        .frame_end(frame_end_p), .hold(hold_p), .read_ack(read_ack_p), .address(address_p),
        .parallel_out(parallel_out_p), .full(full_p), .overrun(overrun_p)
    );

    task automatic step(input logic bv, input logic [7:0] bd, input logic fe, input logic ack);
        @(negedge clock);
        byte_valid = bv;
        byte_data  = bd;
        frame_end  = fe;
        read_ack   = ack;
    endtask

    task automatic send_frame(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 8'(base + i), (i == n - 1), 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic issue_read(input logic [3:0] a, input logic [7:0] e);
        @(negedge clock);
        byte_valid = 1'b0;
        frame_end  = 1'b0;
        read_ack   = 1'b0;
        address    = a;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        byte_valid = 1'b0; frame_end = 1'b0; hold = 1'b0; read_ack = 1'b0; address = '0;
        byte_valid_p = 1'b0; frame_end_p = 1'b0; address_p = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] ra[2];
        logic [7:0] re[2];
        apply_reset();
        checks++;
        if (parallel_out !== 8'h00) begin errors++; $display("FAIL reset_pout got %h want 00", parallel_out); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        ra = '{4'd0, 4'd12};
        re = '{8'h00, 8'h00};
        for (int i = 0; i < 2; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL reset_read addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
    endtask

    task automatic test_good_frame();
        logic [3:0] ra[4];
        logic [7:0] re[4];
        apply_reset();
        send_frame(8'h10, 12);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL good_full got %b want 1", full); end
        ra = '{4'd0, 4'd11, 4'd12, 4'd13};
        re = '{8'h10, 8'h1B, 8'h80, 8'h00};
        for (int i = 0; i < 4; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL good_read addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
        // Frame end arriving one cycle after the last byte is also a good frame.
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        issue_read(4'd5, 8'h85);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++;
        if (parallel_out !== exp) begin errors++; $display("FAIL late_end_read got %h want %h", parallel_out, exp); end
    endtask

    task automatic test_hold();
        logic [3:0] ra[2];
        logic [7:0] re[2];
        apply_reset();
        send_frame(8'hA0, 12);
        @(negedge clock);
        hold = 1'b1;
        send_frame(8'hB0, 12);
        ra = '{4'd0, 4'd12};
        re = '{8'hA0, 8'hA0};
        for (int i = 0; i < 2; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL hold_read addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL pend_overrun got %b want 1", overrun); end
        issue_read(4'd12, 8'hE0);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++;
        if (parallel_out !== exp) begin errors++; $display("FAIL pend_status got %h want %h", parallel_out, exp); end
        @(negedge clock);
        hold = 1'b0;
        ra = '{4'd0, 4'd12};
        re = '{8'hB0, 8'hC0};
        for (int i = 0; i < 2; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL release_read addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
    endtask

    task automatic test_bad_frames();
        logic [3:0] ra[3];
        logic [7:0] re[3];
        apply_reset();
        send_frame(8'h30, 12);
        send_frame(8'h50, 11);
        send_frame(8'h60, 13);
        ra = '{4'd0, 4'd11, 4'd12};
        re = '{8'h30, 8'h3B, 8'h02};
        for (int i = 0; i < 3; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if ((i < 2 && parallel_out !== exp) || (i == 2 && parallel_out[4:0] !== exp[4:0])) begin
                errors++; $display("FAIL bad_read addr %0d got %h want %h", ra[i], parallel_out, exp);
            end
        end
        repeat (38) step(1'b0, 8'h00, 1'b1, 1'b0);
        issue_read(4'd12, 8'h1F);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++;
        if (parallel_out[4:0] !== exp[4:0]) begin errors++; $display("FAIL bad_saturate got %h want %h", parallel_out[4:0], exp[4:0]); end
    endtask

    task automatic test_ack_race();
        apply_reset();
        send_frame(8'h11, 12);
        send_frame(8'h21, 12);
        checks++;
        if (full !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL double_commit got %b%b want 11", full, overrun); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (full !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ack_clear got %b%b want 00", full, overrun); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h31 + 16 * r + i), (i == 11), (i == 11));
            step(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (full !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ack_commit_race %0d got %b%b want 10", r, full, overrun); end
        end
        issue_read(4'd0, 8'h41);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++;
        if (parallel_out !== exp) begin errors++; $display("FAIL ack_race_read got %h want %h", parallel_out, exp); end
    endtask

    task automatic test_async_reset();
        logic [3:0] ra[3];
        logic [7:0] re[3];
        apply_reset();
        send_frame(8'h10, 12);
        issue_read(4'd0, 8'h10);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++;
        if (parallel_out !== exp) begin errors++; $display("FAIL pre_reset_read got %h want %h", parallel_out, exp); end
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        byte_valid = 1'b0;
        #1;
        checks++;
        if (parallel_out !== 8'h00 || full !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL async_reset_frame got %h %b %b want 00 0 0", parallel_out, full, overrun);
        end
        @(negedge clock);
        reset_n = 1'b1;
        ra = '{4'd5, 4'd12, 4'd0};
        re = '{8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL post_reset_read addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
        send_frame(8'h40, 12);
        ra = '{4'd0, 4'd11, 4'd12};
        re = '{8'h40, 8'h4B, 8'h80};
        for (int i = 0; i < 3; i++) begin
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL recommit_read addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
        @(negedge clock);
        hold = 1'b1;
        send_frame(8'h20, 12);
        issue_read(4'd12, 8'hA0);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++;
        if (parallel_out !== exp) begin errors++; $display("FAIL pend_before_reset got %h want %h", parallel_out, exp); end
        @(negedge clock);
        reset_n = 1'b0;
        hold = 1'b0;
        #1;
        checks++;
        if (parallel_out !== 8'h00 || full !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL async_reset_pend got %h %b %b want 00 0 0", parallel_out, full, overrun);
        end
        @(negedge clock);
        reset_n = 1'b1;
        ra = '{4'd12, 4'd0, 4'd0};
        re = '{8'h00, 8'h00, 8'h70};
        for (int i = 0; i < 3; i++) begin
            if (i == 2) send_frame(8'h70, 12);
            issue_read(ra[i], re[i]);
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out !== exp) begin errors++; $display("FAIL after_pend_reset addr %0d got %h want %h", ra[i], parallel_out, exp); end
        end
    endtask

    task automatic test_param();
        logic [4:0] a;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            byte_valid_p = 1'b1;
            byte_data_p  = 8'(8'h60 + i);
            frame_end_p  = (i == 19);
        end
        @(negedge clock);
        byte_valid_p = 1'b0;
        frame_end_p  = 1'b0;
        for (int i = 0; i < 22; i++) begin
            a = (i < 20) ? 5'(i) : ((i == 20) ? 5'd20 : 5'd31);
            @(negedge clock);
            address_p = a;
            exp_q.push_back((i < 20) ? 8'(8'h60 + i) : ((i == 20) ? 8'h80 : 8'h00));
            @(posedge clock); #1;
            exp = exp_q.pop_front();
            checks++;
            if (parallel_out_p !== exp) begin errors++; $display("FAIL param_read addr %0d got %h want %h", a, parallel_out_p, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_hold();
        test_bad_frames();
        test_ack_race();
        test_async_reset();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_readout.md
# frame_readout

Parametrised successor to the fixed 12-byte thermostat readout mux. It sits between the serial frame decoder and the microcontroller-facing parallel bus. It collects decoded frame bytes into a capture buffer and commits only complete, correctly sized frames into a snapshot buffer. The microcontroller reads the snapshot by address, can freeze updates with `hold` while it reads, and acknowledges with `read_ack`. Overrun and bad-frame status are reported through a status byte.

## Interface
- `FRAME_BYTES`, 12: bytes per valid frame; must be ≥1 and < 2^ADDR_WIDTH.
- `ADDR_WIDTH`, 4: readout address width.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `byte_data`  in  8  decoded byte from the serial decoder.
- `byte_valid`  in  1  one-cycle strobe; `byte_data` is valid this cycle.
- `frame_end`  in  1  one-cycle strobe; the current frame has terminated.
- `hold`  in  1  level; while high, no new frame commits to the snapshot.
- `read_ack`  in  1  one-cycle strobe; the microcontroller has consumed the snapshot.
- `address`  in  ADDR_WIDTH  readout select.
- `parallel_out`  out  8  registered read data.
- `full`  out  1  an unacknowledged snapshot is available.
- `overrun`  out  1  sticky flag; data was lost or an unread snapshot was overwritten.

## Operation
- Storage:
  - `capture[FRAME_BYTES]`, `snapshot[FRAME_BYTES]`: 8-bit entries.
  - `wr_ptr`: counts 0..FRAME_BYTES.
  - `too_long`: flag.
  - `bad_count`: 5 bits, saturates at 31.
- State COLLECT (reset state):
  - On `byte_valid` with `wr_ptr` < FRAME_BYTES: write `capture[wr_ptr]`, then `wr_ptr`++.
  - On `byte_valid` with `wr_ptr` == FRAME_BYTES: drop the byte and set `too_long`.
  - On `frame_end`, the frame is good iff the byte count (including a same-cycle byte) == FRAME_BYTES and `too_long` == 0.
  - Good frame with `hold`=0: commit (copy all of capture to snapshot in one cycle), set `full`. If `full` was already 1 and not acked this cycle, set `overrun`.
  - Good frame with `hold`=1: go to PENDING; the capture buffer stays frozen.
  - Bad frame: `bad_count`++ (saturating); no commit.
  - Any `frame_end`: clear `wr_ptr` and `too_long`.
- State PENDING:
  - `byte_valid` or `frame_end`: discard the input and set `overrun`. `wr_ptr` stays 0.
  - First cycle `hold` is sampled 0: commit as above, return to COLLECT.
  - Inputs arriving in that same cycle are still discarded.
- `read_ack`: clears `full` and `overrun`. A commit or a new overrun event in the same cycle wins, so the flag stays 1.
- Readout:
  - `address` < FRAME_BYTES: `snapshot[address]`.
  - `address` == FRAME_BYTES: status byte {`full`, `overrun`, `pending`, `bad_count[4:0]`}.
  - Any other address: 8'h00.
- `bad_count` clears only on reset.

## Timing
- Reset (asynchronous, while `reset_n`=0):
  - `parallel_out`=0, `full`=0, `overrun`=0.
  - Snapshot and capture contents = 0; `bad_count`=0.
  - State = COLLECT.
  - Reset mid-frame or in PENDING discards everything.
- Read latency:
  - `parallel_out` reflects `address` sampled at edge N, valid after edge N.
  - The value reflects snapshot/status state as of before edge N.
- Commit latency:
  - `frame_end` (with `hold`=0) at edge N: snapshot and `full` update at edge N.
  - A read at edge N+1 returns the new data.
- Hold release:
  - `hold` falls before edge N: commit at edge N.
- Throughput: back-to-back `byte_valid` every cycle is supported, and `frame_end` may coincide with the last byte.

## Test plan
- Good frame, no hold: send FRAME_BYTES=12 bytes 0x10..0x1B, then `frame_end`. Expect addr 0 → 0x10, addr 11 → 0x1B, addr 12 → 0x80, addr 13 → 0x00.
- Hold and release:
  - Commit frame A (0xA0..), set `hold`=1, send frame B (0xB0..) with `frame_end`.
  - Addr 0 stays 0xA0 and status = 0xA0 (`full`, `pending`).
  - Send 1 extra byte: `overrun`=1.
  - Drop `hold`: one cycle later addr 0 = 0xB0.
- Bad frames: send an 11-byte frame, then a 13-byte frame. Snapshot is unchanged, status low bits = 2. After 40 bad frames, `bad_count` = 31.
- Ack race:
  - Two good frames without ack: `overrun`=1.
  - Pulse `read_ack`: `full`=0 and `overrun`=0.
  - Ack in the same cycle as a commit: `full` stays 1.
- Async reset: assert `reset_n`=0 mid-frame (byte 5 of 12) and mid-PENDING. All outputs are 0 immediately. The next 12-byte frame commits normally.
- Parametrisation: with FRAME_BYTES=20, ADDR_WIDTH=5, a 20-byte frame reads back intact, status is at addr 20, and addr 31 → 0x00.
